// File: rtl/ram_1r2w_lvt.sv
// Two-write / one-read RAM using a Live Value Table: each write port owns a
// private bank, and a 1-bit-per-entry LVT steers the read mux to the last writer.
module ram_1r2w_lvt #(
    parameter int BLOCLSIZE = 11,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BLOCLSIZE:0]   w_addr_1,
    input  logic [DATA_W-1:0]    w_din_1,
    input  logic                 w_enb_1,
    input  logic [BLOCLSIZE:0]   w_addr_2,
    input  logic [DATA_W-1:0]    w_din_2,
    input  logic                 w_enb_2,
    input  logic [BLOCLSIZE:0]   r_addr_1,
    input  logic                 r_enb,
    output logic [DATA_W-1:0]    r_dout_1,
    output logic                 r_valid,
    output logic [CNT_W-1:0]     col_cnt
);

    localparam int DEPTH = 2 ** (BLOCLSIZE + 1);

    logic [DATA_W-1:0] bank_1 [DEPTH];
    logic [DATA_W-1:0] bank_2 [DEPTH];
    logic [DEPTH-1:0]  lvt;
    logic              collision;

    assign collision = w_enb_1 && w_enb_2 && (w_addr_1 == w_addr_2);

    // NOTE: the banks carry no reset so they can map onto RAM macros; writes are
    // still suppressed while rst is low. Only the 1-bit LVT is cleared.
    always_ff @(posedge clk) begin
        if (rst && w_enb_1) bank_1[w_addr_1] <= w_din_1;
        if (rst && w_enb_2) bank_2[w_addr_2] <= w_din_2;
    end

    // Port 2 is applied last so it owns the entry on a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvt <= '0;
        end else begin
            if (w_enb_1) lvt[w_addr_1] <= 1'b0;
            if (w_enb_2) lvt[w_addr_2] <= 1'b1;
        end
    end

    // NOTE: non-blocking updates mean this read sees the LVT and bank contents
    // from before the current edge, giving read-before-write for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout_1 <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= r_enb;
            if (r_enb) begin
                r_dout_1 <= lvt[r_addr_1] ? bank_2[r_addr_1] : bank_1[r_addr_1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt <= '0;
        end else if (collision && (col_cnt != '1)) begin
            col_cnt <= col_cnt + CNT_W'(1);
        end
    end

endmodule
